// File: rtl/key_press_conditioner_pkg.sv
// Shared types and helpers for the key press conditioner.
package key_cond_pkg;

  // Conditioner FSM states; LOCKOUT is the reset state.
  typedef enum logic [2:0] {
    LOCKOUT     = 3'd0,
    IDLE        = 3'd1,
    DEB_PRESS   = 3'd2,
    PRESSED     = 3'd3,
    DEB_RELEASE = 3'd4
  } kc_state_t;

  // Counter width must hold the larger of the debounce count and the
  // autorepeat delay.
  function automatic int kc_cnt_width(input int debounce_cycles, input int repeat_delay);
    int m;
    m = (debounce_cycles > repeat_delay) ? debounce_cycles : repeat_delay;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_press_conditioner_if.sv
// Signal bundle between a pushbutton source and the key conditioner.
// There is no valid/ready handshake here: raw is a free-running level,
// press is a one-cycle strobe, held and busy are levels, and state is the
// FSM state mirrored for debug.
interface key_press_conditioner_if;
  import key_cond_pkg::*;

  logic      raw;
  logic      press;
  logic      held;
  logic      busy;
  kc_state_t state;

  modport master (output raw, input press, held, busy, state);
  modport slave  (input raw, output press, held, busy, state);
endinterface

// File: rtl/key_press_conditioner_sync_chain.sv
// Multi-flop synchronizer with a configurable reset level.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/key_press_conditioner.sv
// Pushbutton conditioner: synchronize, debounce, emit press pulse and held
// level, and ignore a key that is already down when reset releases.
// Optional autorepeat is enabled by defining KEY_COND_AUTOREPEAT_EN.
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  key_press_conditioner_if.slave    kif
);

  localparam int          CW       = kc_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY);
  localparam logic        ACT_LO   = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_COND_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes later repeats reuse the same compare.
  localparam logic [CW-1:0] REP_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_PERIOD must be >= 1");
  end

  logic          sync_out;
  logic          p_sync;
  kc_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;
  logic          held_q;
  logic          busy_q;

  // Synchronizer resets to the pressed level so a key held through reset
  // keeps the FSM in LOCKOUT until it is released.
  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (~ACT_LO)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kif.raw),
    .q_o (sync_out)
  );

  assign p_sync = sync_out ^ ACT_LO;

  // Debounce FSM with counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKOUT;
      cnt_q   <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        LOCKOUT: begin
          if (!p_sync) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (p_sync) begin
            state_q <= DEB_PRESS;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (!p_sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!p_sync) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
`ifdef KEY_COND_AUTOREPEAT_EN
          else if (cnt_q == REP_LAST) begin
            press_q <= 1'b1;
            cnt_q   <= REP_RELOAD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        DEB_RELEASE: begin
          if (p_sync) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= LOCKOUT;
          cnt_q   <= '0;
          held_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign kif.press = press_q;
  assign kif.held  = held_q;
  assign kif.busy  = busy_q;
  assign kif.state = state_q;

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Sits between a raw DE1-SoC pushbutton and the point/light-field logic. Replaces the separate synchronizer and edge-detect chain with one block.
- Synchronizes the asynchronous key and debounces it with a stable-count FSM.
- Emits a one-cycle `press` pulse per accepted press and a debounced `held` level.
- Ignores a key that is already held when reset releases.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2 to 4.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a change; minimum 1.
- ACTIVE_LOW, 1, 1 means raw=0 is "pressed" (DE1 KEY); 0 means raw=1 is "pressed".
- REPEAT_DELAY, 64, used only with AUTOREPEAT_EN: held cycles before the first repeat pulse.
- REPEAT_PERIOD, 16, used only with AUTOREPEAT_EN: cycles between subsequent repeat pulses.

Ports:
- clk  input  1  system clock (divided board clock or CLOCK_50 in simulation)
- rst  input  1  asynchronous active-high reset
- raw  input  1  unsynchronized pushbutton level
- press  output  1  registered one-cycle pulse per accepted press
- held  output  1  registered debounced "pressed" level
- busy  output  1  high whenever the FSM is not in IDLE or PRESSED (debug/LED)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Polarity: `p_sync` is the last synchronizer stage XOR'd with ACTIVE_LOW, so 1 means pressed.
- Synchronizer reset value: flops reset to the pressed-equivalent level, so a key held through reset is seen as pressed.
- Output reset values: press=0, held=0, busy=1. FSM resets to LOCKOUT; counter resets to 0.
- FSM states (enum in package):
  - LOCKOUT: wait for p_sync=0, then go to IDLE.
  - IDLE: on p_sync=1, counter←0 and go to DEB_PRESS.
  - DEB_PRESS:
    - If p_sync=0, go to IDLE and clear the counter.
    - Else if counter==DEBOUNCE_CYCLES-1, go to PRESSED.
    - Else counter+1.
  - PRESSED: on p_sync=0, counter←0 and go to DEB_RELEASE.
  - DEB_RELEASE:
    - If p_sync=1, go back to PRESSED; no new pulse.
    - Else if counter==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else counter+1.
- Output timing:
  - press is high exactly on the first cycle the state register equals PRESSED after coming from DEB_PRESS.
  - held is high while the state is PRESSED or DEB_RELEASE.
- Latency: with raw held stable, press rises SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after the first edge that samples raw pressed. held rises on the same edge as press.
- Release latency: held falls SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after raw release.
- Bounce handling:
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles in DEB_PRESS yields no pulse.
  - A glitch in DEB_RELEASE neither drops held nor re-pulses.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY)+1). The counter saturates and never wraps.
- Reset mid-operation: an immediate asynchronous return to LOCKOUT with outputs at reset values. Any pulse in flight is discarded.

Optional Feature:
- Macro: KEY_COND_AUTOREPEAT_EN.
- Defined: in PRESSED the counter keeps counting.
  - At REPEAT_DELAY cycles, press pulses once.
  - After that, press pulses every REPEAT_PERIOD cycles while the FSM stays in PRESSED.
  - Entering DEB_RELEASE cancels repeat.
  - Returning from DEB_RELEASE to PRESSED restarts the count at 0 with no pulse.
- Undefined: exactly one press pulse per accepted press. The REPEAT_* parameters are ignored and their logic is absent.

Decomposition:
- Package key_cond_pkg:
  - state enum `kc_state_t` (LOCKOUT, IDLE, DEB_PRESS, PRESSED, DEB_RELEASE)
  - function `kc_cnt_width` computing the counter width.
- One sub-module, sync_chain:
  - parameterized SYNC_STAGES-flop synchronizer with a reset-value parameter.
  - instantiated once for raw.

Test Plan:
- Reset with raw=1 (released, ACTIVE_LOW=1), then raw=0 held 10 cycles with defaults → press high for exactly 1 cycle, 7 edges after the first sampling edge; held=1 from that edge.
- raw=0 for 2 cycles then 1 (bounce), defaults → press stays 0, held stays 0, FSM back in IDLE; busy high only during debounce.
- Held press, then raw=1 for 2 cycles then 0 again → held stays 1, no second press pulse.
- raw=0 held while rst asserted and then released → press=0 and held=0 until raw released; the next full press yields one pulse.
- rst asserted on the cycle press would fire → press never asserts; all outputs reset immediately (asynchronously).
- With KEY_COND_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, key held 30 cycles after acceptance → pulses at acceptance and at +8, +12, +16, +20, +24, +28 cycles.
